// File: rtl/hack_data_memory.sv
// hack_data_memory: Hack data memory, screen shadow, keyboard register and buffered screen-write FIFO
module hack_data_memory #(
  parameter int FIFO_DEPTH = 4,
  parameter int RAM_WORDS  = 16384,
  parameter int SCR_WORDS  = 8192
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [14:0] addressM,
  input  logic        writeM,
  input  logic [15:0] outM,
  output logic [15:0] inM,
  output logic        stall,
  input  logic [15:0] kbd_data,
  input  logic        kbd_strobe,
  output logic [12:0] scr_addr,
  output logic [15:0] scr_data,
  output logic        scr_valid,
  input  logic        scr_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int RW = $clog2(RAM_WORDS);
  localparam int SW = $clog2(SCR_WORDS);
  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);

  logic [15:0] ram    [RAM_WORDS];
  logic [15:0] shadow [SCR_WORDS];
  logic [12:0] f_addr [FIFO_DEPTH];
  logic [15:0] f_data [FIFO_DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0]   count;
  logic [15:0]   kbd;
  logic is_ram, is_scr, is_kbd, full, push, pop;

  assign is_ram    = ~addressM[14];
  assign is_scr    = addressM[14:13] == 2'b10;
  assign is_kbd    = addressM == 15'h6000;
  assign full      = count == FULL;
  assign push      = writeM & is_scr & ~full;
  assign scr_valid = count != '0;
  assign pop       = scr_valid & scr_ready;
  // Stall looks only at the registered count, so a same-cycle pop cannot release it
  assign stall     = writeM & is_scr & full;

  // Zero-latency read mux; unmapped addresses read as zero
  always_comb begin
    inM      = is_ram ? ram[addressM[RW-1:0]] : is_scr ? shadow[addressM[SW-1:0]] : is_kbd ? kbd : 16'h0000;
    scr_addr = scr_valid ? f_addr[head] : 13'h0000;
    scr_data = scr_valid ? f_data[head] : 16'h0000;
  end

  // Storage arrays carry no reset so RAM and shadow survive a reset pulse
  always_ff @(posedge clock) begin
    if (writeM && is_ram) ram[addressM[RW-1:0]] <= outM;
    if (push) begin
      shadow[addressM[SW-1:0]] <= outM;
      f_addr[tail]             <= addressM[12:0];
      f_data[tail]             <= outM;
    end
  end

  // FIFO bookkeeping and keyboard latch; reset drops any queued screen writes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      kbd   <= 16'h0000;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (kbd_strobe) kbd <= kbd_data;
    end
  end
endmodule

// File: tb/tb_hack_data_memory.sv
// tb_hack_data_memory: randomized scoreboard bench for hack_data_memory against a behavioural memory-map model
module tb_hack_data_memory;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [14:0] addressM;
  logic        writeM;
  logic [15:0] outM;
  logic [15:0] inM;
  logic        stall;
  logic [15:0] kbd_data;
  logic        kbd_strobe;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic        scr_valid;
  logic        scr_ready;

  hack_data_memory #(.FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .addressM(addressM), .writeM(writeM), .outM(outM),
    .inM(inM), .stall(stall), .kbd_data(kbd_data), .kbd_strobe(kbd_strobe),
    .scr_addr(scr_addr), .scr_data(scr_data), .scr_valid(scr_valid), .scr_ready(scr_ready)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [15:0] ram_m [16384];
  bit          ram_k [16384];
  logic [15:0] scr_m [8192];
  bit          scr_k [8192];
  logic [15:0] kbd_m = 16'h0000;
  int          cnt = 0;
  logic [28:0] exp_q [$];

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endfunction

  function automatic void ref_read(input logic [14:0] a, output bit known, output logic [15:0] v);
    known = 1'b1;
    v = 16'h0000;
    if (!a[14]) begin
      known = ram_k[a[13:0]];
      v = ram_m[a[13:0]];
    end else if (!a[13]) begin
      known = scr_k[a[12:0]];
      v = scr_m[a[12:0]];
    end else if (a == 15'h6000) v = kbd_m;
  endfunction

  // One CPU cycle: drive, check combinational outputs against the model, advance the model, step the clock
  task automatic cyc(input logic [14:0] a, input logic w, input logic [15:0] d, input logic r,
                     input logic s = 1'b0, input logic [15:0] k = 16'h0000);
    bit known;
    logic [15:0] v;
    bit is_scr, acc, pp;
    addressM = a; writeM = w; outM = d; scr_ready = r; kbd_strobe = s; kbd_data = k;
    #2;
    ref_read(a, known, v);
    if (known) chk("inM", {16'h0, inM}, {16'h0, v});
    is_scr = a[14:13] == 2'b10;
    chk("stall", {31'h0, stall}, {31'h0, w && is_scr && cnt == DEPTH});
    chk("scr_valid", {31'h0, scr_valid}, {31'h0, cnt != 0});
    if (cnt == 0) chk("scr_idle", {3'h0, scr_addr, scr_data}, 32'h0);
    acc = w && is_scr && cnt < DEPTH;
    pp = r && cnt != 0;
    if (w && !a[14]) begin
      ram_m[a[13:0]] = d;
      ram_k[a[13:0]] = 1'b1;
    end
    if (acc) begin
      scr_m[a[12:0]] = d;
      scr_k[a[12:0]] = 1'b1;
      exp_q.push_back({a[12:0], d});
    end
    cnt = cnt + int'(acc) - int'(pp);
    if (s) kbd_m = k;
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitor: every handshake on the screen port must match the oldest accepted write
  always @(negedge clock) begin
    if (reset && scr_valid && scr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scr_pop: got %h/%h expected no entry", scr_addr, scr_data);
      end else chk("scr_pop", {3'h0, scr_addr, scr_data}, {3'h0, exp_q.pop_front()});
    end
  end

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cyc(15'h7FFF, 1'b0, 16'h0, 1'b1);
  endtask

  initial begin
    reset = 1'b0; addressM = 15'h6000; writeM = 1'b0; outM = 16'h0;
    kbd_data = 16'h0; kbd_strobe = 1'b0; scr_ready = 1'b0;
    #3;
    chk("rst_valid", {31'h0, scr_valid}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_head", {3'h0, scr_addr, scr_data}, 32'h0);
    chk("rst_kbd", {16'h0, inM}, 32'h0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    cyc(15'h0011, 1'b1, 16'h5555, 1'b0);
    cyc(15'h0010, 1'b1, 16'h1234, 1'b0);
    chk("ram_rt", {16'h0, inM}, 32'h1234);
    cyc(15'h0011, 1'b0, 16'hDEAD, 1'b0);
    chk("ram_other", {16'h0, inM}, 32'h5555);

    cyc(15'h4005, 1'b1, 16'hFFFF, 1'b1);
    cyc(15'h4005, 1'b0, 16'h0000, 1'b1);
    chk("scr_shadow", {16'h0, inM}, 32'hFFFF);

    for (int i = 0; i < 4; i++) cyc(15'h4000 + 15'(i), 1'b1, 16'(i + 1), 1'b0);
    cyc(15'h4004, 1'b1, 16'h0005, 1'b0);
    chk("full_stall", {31'h0, stall}, 32'h1);
    cyc(15'h4004, 1'b1, 16'h0005, 1'b1);
    chk("stall_release", {31'h0, stall}, 32'h0);
    cyc(15'h4004, 1'b1, 16'h0005, 1'b0);
    chk("fifth_shadow", {16'h0, inM}, 32'h0005);
    drain();

    cyc(15'h6000, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0041);
    chk("kbd_set", {16'h0, inM}, 32'h0041);
    cyc(15'h6000, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0000);
    chk("kbd_clr", {16'h0, inM}, 32'h0000);
    cyc(15'h6001, 1'b0, 16'h0, 1'b0);
    chk("none_rd", {16'h0, inM}, 32'h0000);
    cyc(15'h6000, 1'b1, 16'h7777, 1'b0);
    chk("kbd_wr_ign", {16'h0, inM}, 32'h0000);

    cyc(15'h4100, 1'b1, 16'hA001, 1'b0);
    cyc(15'h4101, 1'b1, 16'hA002, 1'b0);
    cyc(15'h4102, 1'b1, 16'hA003, 1'b1);
    cyc(15'h4103, 1'b1, 16'hA004, 1'b1);
    drain();

    for (int i = 0; i < 3; i++) cyc(15'h4200 + 15'(i), 1'b1, 16'hB000 + 16'(i), 1'b0);
    addressM = 15'h4203; writeM = 1'b1; outM = 16'hBBBB;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", {31'h0, scr_valid}, 32'h0);
    chk("arst_stall", {31'h0, stall}, 32'h0);
    chk("arst_head", {3'h0, scr_addr, scr_data}, 32'h0);
    exp_q.delete();
    cnt = 0;
    kbd_m = 16'h0000;
    writeM = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    cyc(15'h0010, 1'b0, 16'h0, 1'b0);
    chk("ram_keep", {16'h0, inM}, 32'h1234);

    for (int i = 0; i < 400; i++) begin
      logic [14:0] a;
      case ($urandom_range(0, 3))
        0: a = 15'($urandom_range(0, 31));
        1: a = 15'h4000 + 15'($urandom_range(0, 31));
        2: a = 15'h6000;
        default: a = 15'h6001 + 15'($urandom_range(0, 15'h1FFE));
      endcase
      cyc(a, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
          $urandom_range(0, 7) == 0, 16'($urandom));
    end
    drain();
    chk("drained", exp_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hack_data_memory.md
Name: hack_data_memory

Overview:
- Data-memory and memory-mapped I/O stage directly downstream of the Hack CPU.
- Consumes the CPU's addressM, writeM and outM, and returns inM combinationally.
- Holds 16K words of RAM, an 8K-word screen shadow and the keyboard register.
- Forwards every screen write to an external video writer through a small buffered valid/ready FIFO, and raises stall when that FIFO cannot accept a write.

Parameters:
- FIFO_DEPTH, 4: screen-write FIFO entries; power of two, at least 2.
- RAM_WORDS, 16384: general RAM words, mapped at 0x0000-0x3FFF.
- SCR_WORDS, 8192: screen shadow words, mapped at 0x4000-0x5FFF.

Ports:
- clock, in, 1: single system clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-low; 0 resets the block.
- addressM, in, 15: CPU data address.
- writeM, in, 1: CPU write strobe for the current cycle.
- outM, in, 16: CPU write data.
- inM, out, 16: read data for addressM, combinational.
- stall, out, 1: CPU clock-enable hold; 1 means the CPU must repeat the current instruction.
- kbd_data, in, 16: key code from the keyboard front end; 0 means no key.
- kbd_strobe, in, 1: one-cycle pulse; latch kbd_data.
- scr_addr, out, 13: screen word offset of the FIFO head.
- scr_data, out, 16: screen data of the FIFO head.
- scr_valid, out, 1: FIFO not empty.
- scr_ready, in, 1: video writer accepts the head this cycle.

Behaviour:
- Address decode:
  - RAM when addressM[14]=0.
  - SCREEN when addressM[14:13]=2'b10.
  - KBD when addressM=0x6000.
  - NONE for 0x6001-0x7FFF.
- Reads, zero latency, purely combinational from addressM:
  - RAM and SCREEN return the array word.
  - KBD returns the keyboard register.
  - NONE returns 0x0000.
- RAM write: when writeM=1 and RAM, mem[addressM] <= outM at the edge. A same-cycle read shows the old value; the next cycle shows the new value.
- SCREEN write, accepted when writeM=1, SCREEN and count<FIFO_DEPTH:
  - shadow[addressM[12:0]] <= outM.
  - The pair {addressM[12:0], outM} is pushed at the tail.
- SCREEN write with count==FIFO_DEPTH:
  - stall=1 combinationally.
  - The shadow is not written and nothing is pushed; the CPU re-presents the write next cycle.
  - stall depends on the registered count only; a pop in the same cycle does not clear stall.
- stall=0 in every other case.
- Writes to KBD and NONE are ignored without error; stall=0.
- FIFO:
  - Registered count, head pointer and tail pointer; pointers wrap modulo FIFO_DEPTH.
  - scr_valid = (count!=0).
  - scr_addr and scr_data show the head entry and stay stable while scr_valid=1 and scr_ready=0.
  - Pop on scr_valid & scr_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance (legal when 0<count<FIFO_DEPTH; at count==0 only the push applies).
  - scr_ready while empty has no effect.
  - Entries leave in strict write order; duplicate addresses are not merged.
- Keyboard register:
  - kbd_strobe=1 latches kbd_data at the edge.
  - It holds until the next strobe.
  - Reads of 0x6000 in the strobe cycle return the old value.
- Reset (reset=0), asynchronous:
  - count=0, pointers=0, keyboard register=0x0000.
  - Therefore scr_valid=0 and stall=0.
  - scr_addr and scr_data are driven 0 while empty.
  - RAM and shadow contents are NOT cleared.
- Reset mid-operation: FIFO entries in flight are discarded; the video writer must tolerate an incomplete stream. Release is taken at the next rising edge after reset returns to 1.
- X-safety: writeM=0 never modifies any state, whatever the values on addressM and outM.

Test Plan:
- RAM round trip: write 0x1234 to address 0x0010, then read 0x0010 the next cycle -> inM=0x1234; a read of 0x0011 returns its prior value.
- Screen passthrough with scr_ready=1: write 0xFFFF to 0x4005 -> next cycle scr_valid=1, scr_addr=0x0005, scr_data=0xFFFF, popped that cycle; a read of 0x4005 returns 0xFFFF.
- FIFO full and stall with scr_ready=0:
  - Write 4 screen words 0x4000-0x4003 (data 1-4) -> count=4.
  - 5th write to 0x4004 -> stall=1 and shadow[4] unchanged.
  - Raise scr_ready for one cycle -> head 0x0000/0x0001 pops.
  - Next cycle stall=0 and the 5th write is accepted.
  - Drain order observed at the FIFO head: 2, 3, 4, 5.
- Keyboard: kbd_data=0x0041 with kbd_strobe pulse -> read of 0x6000 returns 0x0041 from the next cycle; strobe with 0 -> returns 0x0000; a read of 0x6001 returns 0x0000; a write to 0x6000 with 0x7777 leaves the register at 0x0000.
- Simultaneous push/pop at count=2 -> count stays 2 and order is preserved.
- Asynchronous reset mid-stream: with 3 entries queued, drive reset=0 between edges -> scr_valid=0 and stall=0 immediately; after release the RAM word at 0x0010 still reads 0x1234.
